// File: rtl/blowfish128_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blowfish128_pkg
//  Description : Shared types, constants and the subkey-pair helper for the
//                Blowfish-128 encrypt/decrypt cores.
//  Revision    : 1.0 - initial release
// ============================================================================
package blowfish128_pkg;

    // Number of Feistel rounds supported by the 128-bit variant.
    localparam int ROUNDS_128 = 8;

    // Round controller states shared by the encryptor and decryptor.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WHITEN = 3'd1,
        REQ    = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // K[idx] = {P(2*idx+1), P(2*idx+2)}; p[0] holds P1.
    function automatic logic [63:0] subkey_pair(input logic [3:0] idx,
                                                input logic [31:0] p [20]);
        return {p[{idx, 1'b0}], p[{idx, 1'b1}]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/blowfish128_decrypt_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : blowfish128_decrypt_core_if
//  Description : Request/response link between a Blowfish core and the shared
//                F-function unit (X/ffunc_enable out, Y/ffunc_ready back).
//  Revision    : 1.0 - initial release
// ============================================================================
interface blowfish128_decrypt_core_if;

    logic [63:0] X;
    logic        ffunc_enable;
    logic [63:0] Y;
    logic        ffunc_ready;

    // The Feistel core issues requests.
    modport master (
        output X,
        output ffunc_enable,
        input  Y,
        input  ffunc_ready
    );

    // The F-function unit serves them.
    modport slave (
        input  X,
        input  ffunc_enable,
        output Y,
        output ffunc_ready
    );

endinterface
`default_nettype wire

// File: rtl/blowfish128_decrypt_core.sv
`default_nettype none
// ============================================================================
//  Module      : blowfish128_decrypt_core
//  Description : Blowfish-128 decryptor. Whitens the ciphertext with K8/K9,
//                then runs 8 Feistel rounds with subkeys K7..K0, borrowing
//                an external F-function unit for each round.
//  Revision    : 1.0 - initial release
// ============================================================================
module blowfish128_decrypt_core
    import blowfish128_pkg::*;
#(
    parameter int ROUNDS      = 8,
    parameter int TIMEOUT_CYC = 0
) (
    input  wire logic          Clk,
    input  wire logic          Rst,
    input  wire logic          Enable,
    input  wire logic          start,
    input  wire logic [127:0]  cipherText,
    output      logic [127:0]  plainText,
    output      logic          plainReady,
    output      logic          busy,
    output      logic          ffunc_err,
    input  wire logic          skey_ready,
    input  wire logic [31:0]   P1,
    input  wire logic [31:0]   P2,
    input  wire logic [31:0]   P3,
    input  wire logic [31:0]   P4,
    input  wire logic [31:0]   P5,
    input  wire logic [31:0]   P6,
    input  wire logic [31:0]   P7,
    input  wire logic [31:0]   P8,
    input  wire logic [31:0]   P9,
    input  wire logic [31:0]   P10,
    input  wire logic [31:0]   P11,
    input  wire logic [31:0]   P12,
    input  wire logic [31:0]   P13,
    input  wire logic [31:0]   P14,
    input  wire logic [31:0]   P15,
    input  wire logic [31:0]   P16,
    input  wire logic [31:0]   P17,
    input  wire logic [31:0]   P18,
    input  wire logic [31:0]   P19,
    input  wire logic [31:0]   P20,
    blowfish128_decrypt_core_if.master ff
);

    // Round controller cannot be built for any other round count.
    generate
        if (ROUNDS != ROUNDS_128) begin : g_rounds_check
            $error("blowfish128_decrypt_core: ROUNDS must be 8");
        end
    endgenerate

    // Watchdog counter is sized for the configured limit; width 1 when unused.
    localparam int          c_WCNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [2:0]  c_LAST_IDX = 3'(ROUNDS - 1);

    state_t                 r_state;
    logic [2:0]             r_idx;
    logic [63:0]            r_cl;
    logic [63:0]            r_cr;
    logic [63:0]            r_dl;
    logic [63:0]            r_dr;
    logic [63:0]            r_x;
    logic                   r_ffunc_enable;
    logic                   r_plain_ready;
    logic                   r_busy;
    logic                   r_err;
    logic [c_WCNT_W-1:0]    r_wcnt;

    logic [31:0]            w_p [20];
    logic [63:0]            w_k8;
    logic [63:0]            w_k9;
    logic [63:0]            w_k_round;
    logic                   w_wd_expired;

    assign w_p = '{P1,  P2,  P3,  P4,  P5,  P6,  P7,  P8,  P9,  P10,
                   P11, P12, P13, P14, P15, P16, P17, P18, P19, P20};

    assign w_k8      = subkey_pair(4'd8, w_p);
    assign w_k9      = subkey_pair(4'd9, w_p);
    assign w_k_round = subkey_pair({1'b0, r_idx}, w_p);

    // Final WAIT cycle allowed before the watchdog fires (never when disabled).
    assign w_wd_expired = (TIMEOUT_CYC > 0) &&
                          (r_wcnt == c_WCNT_W'(TIMEOUT_CYC - 1));

    assign plainText       = {r_dl, r_dr};
    assign plainReady      = r_plain_ready;
    assign busy            = r_busy;
    assign ffunc_err       = r_err;
    assign ff.X            = r_x;
    assign ff.ffunc_enable = r_ffunc_enable;

    // Round controller: state, datapath and all registered outputs; Enable=0 freezes everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= IDLE;
            r_idx          <= c_LAST_IDX;
            r_cl           <= '0;
            r_cr           <= '0;
            r_dl           <= '0;
            r_dr           <= '0;
            r_x            <= '0;
            r_ffunc_enable <= 1'b0;
            r_plain_ready  <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_wcnt         <= '0;
        end else if (Enable) begin
            case (r_state)
                IDLE, DONE: begin
                    if (start && skey_ready) begin
                        r_cl          <= cipherText[127:64];
                        r_cr          <= cipherText[63:0];
                        r_idx         <= c_LAST_IDX;
                        r_plain_ready <= 1'b0;
                        r_err         <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= WHITEN;
                    end
                end

                WHITEN: begin
                    if (!skey_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        // Undo the encryptor's output whitening and half swap.
                        r_dl    <= r_cr ^ w_k8;
                        r_dr    <= r_cl ^ w_k9;
                        r_state <= REQ;
                    end
                end

                REQ: begin
                    if (!skey_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_x            <= r_dr;
                        r_wcnt         <= '0;
                        r_ffunc_enable <= 1'b1;
                        r_state        <= WAIT;
                    end
                end

                WAIT: begin
                    if (!skey_ready) begin
                        r_ffunc_enable <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= IDLE;
                    end else if (ff.ffunc_ready) begin
                        r_dl           <= r_dr ^ w_k_round;
                        r_dr           <= r_dl ^ ff.Y;
                        r_ffunc_enable <= 1'b0;
                        if (r_idx == 3'd0) begin
                            r_plain_ready <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= DONE;
                        end else begin
                            r_idx   <= r_idx - 3'd1;
                            r_state <= REQ;
                        end
                    end else if (w_wd_expired) begin
                        r_err          <= 1'b1;
                        r_ffunc_enable <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end

                default: begin
                    r_ffunc_enable <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
